// File: rtl/regfile_param.sv
// regfile_param: parameterised register file with two write ports, NRD
// combinational read ports and a post-reset clear sequence that zeroes
// registers 1..DEPTH-1 one per cycle before writes are accepted.
// Register 0 is hard-wired to zero.
// Optional feature: define REGFILE_PARAM_BYPASS_EN to forward same-cycle
// write data to matching reads (port B has priority over port A).
module regfile_param #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int NRD   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 ready,
  input  logic                 we3,
  input  logic [$clog2(DEPTH)-1:0] wa3,
  input  logic [WIDTH-1:0]     wd3,
  input  logic                 we4,
  input  logic [$clog2(DEPTH)-1:0] wa4,
  input  logic [WIDTH-1:0]     wd4,
  input  logic [NRD*$clog2(DEPTH)-1:0] ra,
  output logic [NRD*WIDTH-1:0] rd
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;

  logic [0:0]       state;
  logic [AW-1:0]    clear_cnt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_a;
  logic             wr_b;

  assign ready = (state == RUN);

  // A write happens only in RUN, outside reset, to a nonzero address; port A
  // yields to port B when both target the same register.
  assign wr_a = ready && !reset && we3 && (wa3 != '0) && !(we4 && (wa4 == wa3));
  assign wr_b = ready && !reset && we4 && (wa4 != '0);

  // Clear-sequence control: reset restarts at register 1, RUN is entered on
  // the edge that clears the last register and is held until the next reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= CLEAR;
      clear_cnt <= AW'(1);
    end else if (state == CLEAR) begin
      clear_cnt <= clear_cnt + AW'(1);
      if (clear_cnt == AW'(DEPTH - 1)) begin
        state <= RUN;
      end
    end
  end

  // Register storage: zeroed one entry per cycle during CLEAR, written by the
  // two ports in RUN; contents are deliberately left untouched by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR) begin
        mem[clear_cnt] <= '0;
      end else begin
        if (wr_a) begin
          mem[wa3] <= wd3;
        end
        if (wr_b) begin
          mem[wa4] <= wd4;
        end
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < NRD; g++) begin : g_read
      logic [AW-1:0] port_addr;
      assign port_addr = ra[g*AW +: AW];

      // Combinational read: zero in CLEAR and for register 0, otherwise the
      // stored value, optionally overridden by a same-cycle write.
      always_comb begin
        rd[g*WIDTH +: WIDTH] = '0;
        if (ready && (port_addr != '0)) begin
          rd[g*WIDTH +: WIDTH] = mem[port_addr];
`ifdef REGFILE_PARAM_BYPASS_EN
          if (wr_a && (wa3 == port_addr)) begin
            rd[g*WIDTH +: WIDTH] = wd3;
          end
          if (wr_b && (wa4 == port_addr)) begin
            rd[g*WIDTH +: WIDTH] = wd4;
          end
`endif
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: directed and randomized checks of regfile_param against
// a behavioural model (register array plus a count of clear cycles left).
// Also exercises a WIDTH=16, DEPTH=8, NRD=3 instance.
// Build with REGFILE_PARAM_BYPASS_EN defined to expect same-cycle forwarding.
module tb_regfile_param;

  localparam int WIDTH = 32;
  localparam int DEPTH = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  localparam int S_WIDTH = 16;
  localparam int S_DEPTH = 8;
  localparam int S_NRD   = 3;
  localparam int S_AW    = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset = 1'b0;
  logic                 ready;
  logic                 we3 = 1'b0;
  logic [AW-1:0]        wa3 = '0;
  logic [WIDTH-1:0]     wd3 = '0;
  logic                 we4 = 1'b0;
  logic [AW-1:0]        wa4 = '0;
  logic [WIDTH-1:0]     wd4 = '0;
  logic [NRD*AW-1:0]    ra  = '0;
  logic [NRD*WIDTH-1:0] rd;

  logic                     s_reset = 1'b1;
  logic                     s_ready;
  logic                     s_we3 = 1'b0;
  logic [S_AW-1:0]          s_wa3 = '0;
  logic [S_WIDTH-1:0]       s_wd3 = '0;
  logic                     s_we4 = 1'b0;
  logic [S_AW-1:0]          s_wa4 = '0;
  logic [S_WIDTH-1:0]       s_wd4 = '0;
  logic [S_NRD*S_AW-1:0]    s_ra  = '0;
  logic [S_NRD*S_WIDTH-1:0] s_rd;

  regfile_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NRD(NRD)) dut (
    .clk(clk), .reset(reset), .ready(ready),
    .we3(we3), .wa3(wa3), .wd3(wd3),
    .we4(we4), .wa4(wa4), .wd4(wd4),
    .ra(ra), .rd(rd)
  );

  regfile_param #(.WIDTH(S_WIDTH), .DEPTH(S_DEPTH), .NRD(S_NRD)) dut_small (
    .clk(clk), .reset(s_reset), .ready(s_ready),
    .we3(s_we3), .wa3(s_wa3), .wd3(s_wd3),
    .we4(s_we4), .wa4(s_wa4), .wd4(s_wd4),
    .ra(s_ra), .rd(s_rd)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: register contents and number of clear cycles still owed.
  logic [WIDTH-1:0] model_mem [DEPTH];
  int clear_left = DEPTH - 1;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] expected_read(input logic [AW-1:0] addr);
    if (clear_left != 0 || addr == '0) return 32'h0;
`ifdef REGFILE_PARAM_BYPASS_EN
    if (we4 && wa4 == addr) return wd4;
    if (we3 && wa3 == addr) return wd3;
`endif
    return model_mem[addr];
  endfunction

  task automatic check_reads(input string tag);
    check_output({tag, "/ready"}, {31'b0, ready}, {31'b0, (clear_left == 0)});
    for (int p = 0; p < NRD; p++) begin
      check_output($sformatf("%s/rd%0d@%0d", tag, p, ra[p*AW +: AW]),
                   rd[p*WIDTH +: WIDTH], expected_read(ra[p*AW +: AW]));
    end
  endtask

  task automatic apply_stimulus(input logic rst,
                                input logic w3, input logic [AW-1:0] a3, input logic [31:0] d3,
                                input logic w4, input logic [AW-1:0] a4, input logic [31:0] d4,
                                input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    reset = rst;
    we3 = w3; wa3 = a3; wd3 = d3;
    we4 = w4; wa4 = a4; wd4 = d4;
    ra = {r1, r0};
    #1;
  endtask

  // One clock edge; the model follows the rules of the register file.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      clear_left = DEPTH - 1;
    end else if (clear_left > 0) begin
      clear_left--;
      if (clear_left == 0) begin
        for (int i = 1; i < DEPTH; i++) model_mem[i] = '0;
      end
    end else begin
      if (we3 && wa3 != '0) model_mem[wa3] = wd3;
      if (we4 && wa4 != '0) model_mem[wa4] = wd4;
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;

    // Reset, then 31 clear cycles with writes that must be ignored.
    apply_stimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    tick();
    for (int i = 0; i < DEPTH - 1; i++) begin
      apply_stimulus(1'b0, 1'b1, 5'd2, 32'h99, 1'b1, AW'(i + 1), 32'h77, 5'd2, AW'(i + 1));
      check_reads($sformatf("clear%0d", i));
      tick();
    end
    apply_stimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    check_output("ready_after_clear", {31'b0, ready}, 32'h1);
    for (int i = 1; i < DEPTH; i++) begin
      apply_stimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, AW'(i), AW'(DEPTH - i));
      check_reads($sformatf("zero%0d", i));
    end

    // Basic write/read and discarded write to register 0.
    apply_stimulus(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 5'd1, 5'd0);
    tick();
    apply_stimulus(1'b0, 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
    check_output("read5", rd[31:0], 32'hDEADBEEF);
    check_reads("w5");
    tick();
    apply_stimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd5);
    check_output("read0", rd[31:0], 32'h0);
    check_reads("w0");

    // Same-address collision (B wins) and two distinct writes.
    apply_stimulus(1'b0, 1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22, 5'd1, 5'd2);
    tick();
    apply_stimulus(1'b0, 1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 5'd7, 5'd7);
    check_output("collide7", rd[31:0], 32'h22);
    check_reads("col");
    tick();
    apply_stimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd4);
    check_output("dual3", rd[31:0], 32'h33);
    check_output("dual4", rd[63:32], 32'h44);

    // Write while reading the same register: old value unless forwarding.
    apply_stimulus(1'b0, 1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 32'h0, 5'd9, 5'd0);
    tick();
    apply_stimulus(1'b0, 1'b1, 5'd9, 32'hAA, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
`ifdef REGFILE_PARAM_BYPASS_EN
    check_output("bypass9", rd[31:0], 32'hAA);
`else
    check_output("nobypass9", rd[31:0], 32'h55);
`endif
    check_reads("byp");
    tick();
    apply_stimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd0);
    check_output("after9", rd[31:0], 32'hAA);

    // Reset in RUN with a write, restart mid-clear, then full clear again.
    apply_stimulus(1'b0, 1'b1, 5'd2, 32'h2222, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    tick();
    apply_stimulus(1'b1, 1'b1, 5'd10, 32'h1010, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    tick();
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1'b0, 1'b1, 5'd2, 32'hBAD, 1'b0, 5'd0, 32'h0, 5'd2, 5'd10);
      check_reads($sformatf("clrA%0d", i));
      tick();
    end
    apply_stimulus(1'b1, 1'b1, 5'd2, 32'hBAD, 1'b0, 5'd0, 32'h0, 5'd2, 5'd10);
    tick();
    for (int i = 0; i < DEPTH - 1; i++) begin
      apply_stimulus(1'b0, 1'b1, 5'd2, 32'hBAD, 1'b0, 5'd0, 32'h0, 5'd2, 5'd10);
      check_output($sformatf("clrB_ready%0d", i), {31'b0, ready}, 32'h0);
      check_reads($sformatf("clrB%0d", i));
      tick();
    end
    apply_stimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd2, 5'd10);
    check_output("ready_after_restart", {31'b0, ready}, 32'h1);
    check_output("reg2_cleared", rd[31:0], 32'h0);
    check_output("reg10_cleared", rd[63:32], 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      apply_stimulus(1'b0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)), $urandom,
                     1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)), $urandom,
                     AW'($urandom_range(0, DEPTH - 1)), AW'($urandom_range(0, DEPTH - 1)));
      check_reads($sformatf("rand%0d", i));
      tick();
    end
    apply_stimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

    // Small configuration: 7-cycle clear and three independent read ports.
    s_reset = 1'b1;
    tick();
    s_reset = 1'b0;
    for (int i = 0; i < S_DEPTH - 1; i++) begin
      #1;
      check_output($sformatf("s_clear%0d", i), {31'b0, s_ready}, 32'h0);
      tick();
    end
    check_output("s_ready", {31'b0, s_ready}, 32'h1);
    s_we3 = 1'b1; s_wa3 = 3'd1; s_wd3 = 16'h0001;
    s_we4 = 1'b1; s_wa4 = 3'd2; s_wd4 = 16'h0002;
    tick();
    s_we3 = 1'b1; s_wa3 = 3'd3; s_wd3 = 16'h0003;
    s_we4 = 1'b0;
    tick();
    s_we3 = 1'b0;
    s_ra = {3'd3, 3'd2, 3'd1};
    #1;
    check_output("s_rd0", {16'h0, s_rd[15:0]}, 32'h0001);
    check_output("s_rd1", {16'h0, s_rd[31:16]}, 32'h0002);
    check_output("s_rd2", {16'h0, s_rd[47:32]}, 32'h0003);
    s_ra = {3'd1, 3'd3, 3'd0};
    #1;
    check_output("s_rd0_zero", {16'h0, s_rd[15:0]}, 32'h0);
    check_output("s_rd1_swap", {16'h0, s_rd[31:16]}, 32'h0003);
    check_output("s_rd2_swap", {16'h0, s_rd[47:32]}, 32'h0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
